// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority voting per bit,
// optional parity, 1 or 2 stop bits, frame-error / break detection with line recovery.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] MID_M1   = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] MID      = CW'(CPB / 2);
    localparam logic [CW-1:0] MID_P1   = CW'(CPB / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    generate
        if (CPB < 8) begin : g_bad_cpb
            $error("uart_rx_cfg: CLK_FREQ/BAUD_RATE must be at least 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
            $error("uart_rx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RECOVER
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Odd mode wants XOR(payload, parity bit) = 1, even mode wants 0.
    function automatic logic par_mismatch(input logic [DATA_BITS-1:0] payload, input logic pbit);
        return (^{payload, pbit}) ^ ((PARITY == 1) ? 1'b1 : 1'b0);
    endfunction

    logic                 sync1_q, rxs_q;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_err_q, par_err_d;
    logic                 v0_q, v0_d, v1_q, v1_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_det_q, break_det_d;
    logic                 busy_q, busy_d;
    logic                 voted_s, decide_s, wrap_s;
    logic [CW-1:0]        cnt_inc_s;

    // Two-flop synchroniser for the asynchronous serial line (idle high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
        end
    end

    // Next-state and registered-output logic for the receive FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        shreg_d      = shreg_q;
        par_bit_d    = par_bit_q;
        par_err_d    = par_err_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        break_det_d  = 1'b0;
        voted_s      = maj3(v0_q, v1_q, rxs_q);
        decide_s     = (cnt_q == MID_P1);
        wrap_s       = (cnt_q == CNT_LAST);
        cnt_inc_s    = wrap_s ? {CW{1'b0}} : (cnt_q + CW'(1));
        v0_d         = (cnt_q == MID_M1) ? rxs_q : v0_q;
        v1_d         = (cnt_q == MID) ? rxs_q : v1_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (!rxs_q) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                cnt_d = cnt_inc_s;
                if (decide_s && voted_s) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (wrap_s) begin
                    state_d   = S_DATA;
                    bit_idx_d = {BW{1'b0}};
                    par_bit_d = 1'b0;
                    par_err_d = 1'b0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                cnt_d = cnt_inc_s;
                if (decide_s) begin
                    shreg_d = {voted_s, shreg_q[DATA_BITS-1:1]};
                end else if (wrap_s) begin
                    if (bit_idx_q == BIT_LAST) begin
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                cnt_d = cnt_inc_s;
                if (decide_s) begin
                    par_bit_d = voted_s;
                    par_err_d = par_mismatch(shreg_q, voted_s);
                end else if (wrap_s) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                cnt_d = cnt_inc_s;
                if (decide_s) begin
                    if (!voted_s) begin
                        // An all-zero frame (payload, parity, stop) is a break, not a framing error.
                        if ((shreg_q == {DATA_BITS{1'b0}}) && !par_bit_q) begin
                            break_det_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        state_d = S_RECOVER;
                        cnt_d   = {CW{1'b0}};
                    end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        data_d       = shreg_q;
                        data_valid_d = 1'b1;
                        parity_err_d = par_err_q;
                        state_d      = S_IDLE;
                        cnt_d        = {CW{1'b0}};
                    end else begin
                        state_d = S_STOP;
                    end
                end else if (wrap_s) begin
                    stop_idx_d = 1'b1;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_RECOVER: begin
                if (!rxs_q) begin
                    cnt_d = {CW{1'b0}};
                end else if (wrap_s) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CW{1'b0}};
            bit_idx_q    <= {BW{1'b0}};
            stop_idx_q   <= 1'b0;
            shreg_q      <= {DATA_BITS{1'b0}};
            par_bit_q    <= 1'b0;
            par_err_q    <= 1'b0;
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            data_q       <= {DATA_BITS{1'b0}};
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            shreg_q      <= shreg_d;
            par_bit_q    <= par_bit_d;
            par_err_q    <= par_err_d;
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 16 clocks per bit,
// stimulus pushes expected events, per-instance monitors pop and compare.
module tb_uart_rx_cfg;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_v = 3'b111;

    logic [7:0] d0;
    logic       dv0, pe0, fe0, bd0, busy0;
    logic [6:0] d1;
    logic       dv1, pe1, fe1, bd1, busy1;
    logic [7:0] d2;
    logic       dv2, pe2, fe2, bd2, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] q0[$];
    logic [12:0] q1[$];
    logic [12:0] q2[$];
    logic [12:0] act0, act1, act2, exp0, exp1, exp2;
    logic        busy_seen;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_v[0]), .data(d0), .data_valid(dv0),
        .parity_err(pe0), .frame_err(fe0), .break_det(bd0), .busy(busy0));
    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_v[1]), .data(d1), .data_valid(dv1),
        .parity_err(pe1), .frame_err(fe1), .break_det(bd1), .busy(busy1));
    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_v[2]), .data(d2), .data_valid(dv2),
        .parity_err(pe2), .frame_err(fe2), .break_det(bd2), .busy(busy2));

    function automatic logic [12:0] ev(input logic dv, input logic fe, input logic bd,
                                       input logic pe, input logic [8:0] d);
        return {dv, fe, bd, pe, d};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [12:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s unexpected output event actual=%h", nm, act);
    endtask

    // Monitors: output event vector is {data_valid, frame_err, break_det, parity_err, data}.
    always @(negedge clk) begin
        if (dv0 | fe0 | bd0 | pe0) begin
            act0 = {dv0, fe0, bd0, pe0, 1'b0, d0};
            if (q0.size() == 0) unexpected("mon_8n1", act0);
            else begin
                exp0 = q0.pop_front();
                check("mon_8n1", 32'(act0), 32'(exp0));
            end
        end
    end

    always @(negedge clk) begin
        if (dv1 | fe1 | bd1 | pe1) begin
            act1 = {dv1, fe1, bd1, pe1, 2'b00, d1};
            if (q1.size() == 0) unexpected("mon_7e1", act1);
            else begin
                exp1 = q1.pop_front();
                check("mon_7e1", 32'(act1), 32'(exp1));
            end
        end
    end

    always @(negedge clk) begin
        if (dv2 | fe2 | bd2 | pe2) begin
            act2 = {dv2, fe2, bd2, pe2, 1'b0, d2};
            if (q2.size() == 0) unexpected("mon_8n2", act2);
            else begin
                exp2 = q2.pop_front();
                check("mon_8n2", 32'(act2), 32'(exp2));
            end
        end
    end

    task automatic drive_bit(input int idx, input logic v);
        rx_v[idx] = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic idle(input int idx, input int n);
        rx_v[idx] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int idx, input logic [8:0] payload, input int nbits,
                              input int has_par, input logic pbit, input int nstop,
                              input logic [1:0] stop_vals);
        drive_bit(idx, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(idx, payload[i]);
        if (has_par != 0) drive_bit(idx, pbit);
        for (int s = 0; s < nstop; s++) drive_bit(idx, stop_vals[s]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_8n1", 32'({d0, dv0, pe0, fe0, bd0, busy0}), 32'd0);
        check("reset_7e1", 32'({d1, dv1, pe1, fe1, bd1, busy1}), 32'd0);
        check("reset_8n2", 32'({d2, dv2, pe2, fe2, bd2, busy2}), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 back-to-back frames
        q0.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 9'h0A5));
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
        q0.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 9'h03C));
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 2'b11);
        idle(0, 32);

        // 7E1: 0x41 has even weight, so parity bit 1 is a mismatch and 0 is correct
        q1.push_back(ev(1'b1, 1'b0, 1'b0, 1'b1, 9'h041));
        send_frame(1, 9'h041, 7, 1, 1'b1, 1, 2'b11);
        idle(1, 32);
        q1.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 9'h041));
        send_frame(1, 9'h041, 7, 1, 1'b0, 1, 2'b11);
        idle(1, 32);

        // False start: 5 low cycles
        busy_seen = 1'b0;
        rx_v[0] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) rx_v[0] = 1'b1;
            @(negedge clk);
            if (busy0) busy_seen = 1'b1;
        end
        check("false_start_busy_seen", 32'(busy_seen), 32'd1);
        check("false_start_back_idle", 32'(busy0), 32'd0);

        // 8N2: good frame, then second stop bit low, then good frame
        q2.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 9'h099));
        send_frame(2, 9'h099, 8, 0, 1'b0, 2, 2'b11);
        idle(2, 16);
        q2.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 9'h099));
        send_frame(2, 9'h055, 8, 0, 1'b0, 2, 2'b01);
        idle(2, 48);
        q2.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 9'h012));
        send_frame(2, 9'h012, 8, 0, 1'b0, 2, 2'b11);
        idle(2, 32);

        // Break: line low for three frame times, data keeps 0x3C
        q0.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 9'h03C));
        rx_v[0] = 1'b0;
        repeat (480) @(negedge clk);
        check("break_busy_low_line", 32'(busy0), 32'd1);
        rx_v[0] = 1'b1;
        repeat (14) @(negedge clk);
        check("break_busy_recovering", 32'(busy0), 32'd1);
        repeat (8) @(negedge clk);
        check("break_busy_released", 32'(busy0), 32'd0);
        idle(0, 16);

        // Reset in the middle of a 0xFF frame
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        repeat (5) @(negedge clk);
        check("abort_busy_before_rst", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs_in_rst", 32'({d0, dv0, pe0, fe0, bd0, busy0}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(0, 200);
        q0.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 9'h081));
        send_frame(0, 9'h081, 8, 0, 1'b0, 1, 2'b11);
        idle(0, 40);

        check("drain_8n1", 32'(q0.size()), 32'd0);
        check("drain_7e1", 32'(q1.size()), 32'd0);
        check("drain_8n2", 32'(q2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
